// File: rtl/seg_dynamic_scan.sv
// Binary-to-BCD conversion (sequential double-dabble) and six-digit multiplexed scan
// producing the registered sel/seg pair consumed by the 74HC595 shift-out stage.
module seg_dynamic_scan #(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);
    localparam logic [19:0] DATA_MAX = 20'd999_999;

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_next;

    logic [19:0] data_clamped;
    logic [19:0] data_reg;
    logic [19:0] bin_work;
    logic [22:0] bcd_work;
    logic [22:0] bcd_adj;
    logic [23:0] bcd_disp;
    logic [4:0]  iter;
    logic        start_conv;
    logic        last_iter;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [2:0]  n_sig;
    logic [3:0]  nibble;
    logic        dp_on;
    logic [5:0]  sel_next;
    logic [7:0]  seg_next;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    assign data_clamped = (data > DATA_MAX) ? DATA_MAX : data;
    assign start_conv   = (state == IDLE) && (data_clamped != data_reg);
    assign last_iter    = (state == SHIFT) && (iter == 5'd19);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_conv) state_next = SHIFT;
            SHIFT:   if (last_iter)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With the input clamped to 999_999 the partial result before any shift is at
    // most 499_999, so the top nibble never needs the add-3 correction and only
    // its low three bits have to be kept in the scratch register.
    always_comb begin
        bcd_adj = bcd_work;
        for (int k = 0; k < 5; k++) begin
            if (bcd_work[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_work[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_reg <= '0;
            bin_work <= '0;
            bcd_work <= '0;
            iter     <= '0;
            bcd_disp <= '0;
        end else if (start_conv) begin
            data_reg <= data_clamped;
            bin_work <= data_clamped;
            bcd_work <= '0;
            iter     <= '0;
        end else if (state == SHIFT) begin
            bcd_work <= {bcd_adj[21:0], bin_work[19]};
            bin_work <= {bin_work[18:0], 1'b0};
            iter     <= iter + 5'd1;
            if (last_iter) begin
                bcd_disp <= {bcd_adj, bin_work[19]};
            end
        end
    end

    // Scan position; disabling the display parks it on digit 0 with a fresh dwell.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !seg_en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    always_comb begin
        n_sig = 3'd1;
        for (int k = 1; k < 6; k++) begin
            if (bcd_disp[4*k +: 4] != 4'd0) begin
                n_sig = 3'(k + 1);
            end
        end
    end

    always_comb begin
        sel_next = 6'b000000;
        nibble   = bcd_disp[3:0];
        dp_on    = 1'b0;
        case (idx)
            3'd0: begin sel_next = 6'b000001; nibble = bcd_disp[3:0];   dp_on = point[0]; end
            3'd1: begin sel_next = 6'b000010; nibble = bcd_disp[7:4];   dp_on = point[1]; end
            3'd2: begin sel_next = 6'b000100; nibble = bcd_disp[11:8];  dp_on = point[2]; end
            3'd3: begin sel_next = 6'b001000; nibble = bcd_disp[15:12]; dp_on = point[3]; end
            3'd4: begin sel_next = 6'b010000; nibble = bcd_disp[19:16]; dp_on = point[4]; end
            3'd5: begin sel_next = 6'b100000; nibble = bcd_disp[23:20]; dp_on = point[5]; end
            default: begin end
        endcase
    end

    // The minus sign sits just left of the most significant digit, if room remains.
    always_comb begin
        seg_next = 8'hFF;
        if (idx < n_sig) begin
            seg_next = seg_decode(nibble);
        end else if ((idx == n_sig) && sign && (n_sig <= 3'd5)) begin
            seg_next = 8'hBF;
        end
        if (dp_on) begin
            seg_next[7] = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !seg_en) begin
            sel <= '0;
            seg <= 8'hFF;
        end else begin
            sel <= sel_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Directed bench for seg_dynamic_scan with a 10-cycle dwell; outputs are sampled
// on the falling edge and compared against hand-computed segment patterns.
module tb_seg_dynamic_scan;
    localparam logic [15:0] CNT_MAX = 16'd9;
    localparam int DWELL = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int compare_count  = 0;
    int mismatch_count = 0;

    always #5 sys_clk = ~sys_clk;

    seg_dynamic_scan #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .data    (data),
        .point   (point),
        .sign    (sign),
        .seg_en  (seg_en),
        .sel     (sel),
        .seg     (seg)
    );

    task automatic check_output(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic apply_stimulus(input logic [19:0] d, input logic [5:0] p, input logic s);
        data  = d;
        point = p;
        sign  = s;
    endtask

    task automatic check_pair(input string tag, input logic [5:0] exp_sel, input logic [7:0] exp_seg);
        check_output({tag, " sel"}, {2'b00, sel}, {2'b00, exp_sel});
        check_output({tag, " seg"}, seg, exp_seg);
    endtask

    // Returns on the first sample of digit 0 that directly follows digit 5.
    task automatic wait_frame_start(input string tag, output bit found);
        logic [5:0] prev;
        found = 1'b0;
        prev  = sel;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (prev == 6'b100000 && sel == 6'b000001) found = 1'b1;
            else prev = sel;
        end
        check_output({tag, " frame_start"}, {7'b0, found}, 8'h01);
    endtask

    // exp packs digit k pattern into exp[8k+7:8k]; ends on the next frame start.
    task automatic check_frame(input string tag, input logic [47:0] exp);
        bit found;
        wait_frame_start(tag, found);
        if (found) begin
            for (int k = 0; k < 6; k++) begin
                for (int c = 0; c < DWELL; c++) begin
                    check_pair($sformatf("%s d%0d c%0d", tag, k, c), 6'(1 << k), exp[8*k +: 8]);
                    step();
                end
            end
            check_output({tag, " wrap sel"}, {2'b00, sel}, 8'h01);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        seg_en  = 1'b1;
        apply_stimulus(20'd0, 6'b000000, 1'b0);

        repeat (3) begin
            step();
            check_pair("reset hold", 6'b000000, 8'hFF);
        end
        sys_rst = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < DWELL; c++) begin
                check_pair($sformatf("post reset d%0d c%0d", k, c), 6'(1 << k), (k == 0) ? 8'hC0 : 8'hFF);
                step();
            end
        end
        check_pair("post reset wrap", 6'b000001, 8'hC0);

        // Now on the first sample of digit 0; data sampled at the next edge.
        apply_stimulus(20'd123, 6'b000000, 1'b0);
        repeat (21) step();
        check_pair("latency old", 6'b000100, 8'hFF);
        step();
        check_pair("latency new", 6'b000100, 8'hF9);

        apply_stimulus(20'd123456, 6'b000000, 1'b0);
        repeat (25) step();
        check_frame("full 123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

        apply_stimulus(20'd42, 6'b000010, 1'b1);
        repeat (25) step();
        check_frame("neg 42 dp1", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h19, 8'hA4});

        apply_stimulus(20'd654321, 6'b000000, 1'b1);
        repeat (25) step();
        check_frame("neg 654321", {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9});

        apply_stimulus(20'd1_000_000, 6'b000000, 1'b0);
        repeat (25) step();
        check_frame("clamp", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

        apply_stimulus(20'd0, 6'b000000, 1'b1);
        repeat (25) step();
        check_frame("neg zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0});

        apply_stimulus(20'd100, 6'b000000, 1'b0);
        repeat (25) step();
        check_frame("inner zeros", {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0});

        apply_stimulus(20'd12345, 6'b100001, 1'b1);
        repeat (25) step();
        check_frame("neg 12345 dp", {8'h3F, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h12});

        apply_stimulus(20'd0, 6'b000000, 1'b0);
        repeat (25) step();
        check_frame("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

        // Change data five cycles into the conversion of 111.
        apply_stimulus(20'd111, 6'b000000, 1'b0);
        repeat (5) step();
        apply_stimulus(20'd222, 6'b000000, 1'b0);
        repeat (16) step();
        check_pair("midconv before", 6'b000100, 8'hFF);
        for (int c = 0; c < 8; c++) begin
            step();
            check_pair($sformatf("midconv 111 c%0d", c), 6'b000100, 8'hF9);
        end
        repeat (25) step();
        check_frame("midconv 222", {8'hFF, 8'hFF, 8'hFF, 8'hA4, 8'hA4, 8'hA4});

        apply_stimulus(20'd123456, 6'b000000, 1'b0);
        repeat (25) step();
        check_frame("pre enable", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
        repeat (33) step();
        check_pair("digit3 mid", 6'b001000, 8'hB0);
        seg_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_pair($sformatf("disabled c%0d", c), 6'b000000, 8'hFF);
        end
        seg_en = 1'b1;
        for (int c = 0; c < DWELL; c++) begin
            step();
            check_pair($sformatf("reenable c%0d", c), 6'b000001, 8'h82);
        end
        step();
        check_pair("reenable next", 6'b000010, 8'h92);

        apply_stimulus(20'd777777, 6'b000000, 1'b0);
        repeat (5) step();
        sys_rst = 1'b1;
        step();
        check_pair("midshift rst 0", 6'b000000, 8'hFF);
        step();
        check_pair("midshift rst 1", 6'b000000, 8'hFF);
        sys_rst = 1'b0;
        step();
        check_pair("after rst", 6'b000001, 8'hC0);
        repeat (25) step();
        check_frame("reconvert", {8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/seg_dynamic_scan.md
# seg_dynamic_scan

Upstream display-formatting stage for the 74HC595 seven-segment path: converts a 20-bit binary value into six BCD digits with a sequential double-dabble engine. It time-multiplexes the six digits and produces the registered `sel`/`seg` pair that the 595 serial controller shifts out. Leading-zero blanking, a minus sign and per-digit decimal points are handled here, so the shift-out stage stays a pure serializer.

## Interface
- `CNT_MAX`, default 16'd49_999: digit dwell counter terminal value; dwell = CNT_MAX+1 cycles (1 ms at 50 MHz).
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `data`  in  20  unsigned value to display; values >999_999 are clamped to 999_999.
- `point`  in  6  `point[k]`=1 lights the decimal point of digit k (k=0 is units).
- `sign`  in  1  1 = display a minus sign in front of the number.
- `seg_en`  in  1  1 = display on; 0 = blank and hold the scan.
- `sel`  out  6  one-hot digit select, active-high; `sel[k]` drives digit k.
- `seg`  out  8  segment pattern, active-low; `seg[7]`=dp, `seg[6:0]`=g..a.

## Operation
- Conversion FSM, states IDLE and SHIFT:
  - IDLE: if clamped `data` != `data_reg`, capture it into `data_reg`, clear the scratch BCD and go to SHIFT.
  - SHIFT: 20 iterations of add-3-if-≥5 on each of six BCD nibbles, then shift left by one bit. On the 20th iteration, load the result into `bcd_disp` (24 bits) atomically and return to IDLE.
  - Changes on `data` during SHIFT are ignored. They are picked up in the next IDLE cycle, which starts a new conversion.
- Scan counter: `cnt` counts 0..CNT_MAX. At CNT_MAX it wraps to 0 and `idx` advances 0→1→…→5→0.
- Significant digit count `n`: index of the most-significant nonzero nibble of `bcd_disp`, plus 1. When the value is 0, n=1.
- Digit k content, in priority order:
  - k<n: decoded nibble. Patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - k==n, `sign`=1 and n≤5: minus sign, 8'hBF.
  - Otherwise: blank, 8'hFF.
  - If n=6, `sign` is ignored.
- Decimal point: if `point[k]`=1, clear `seg[7]` regardless of content, including on blank digits.
- `seg_en`=0: `cnt`=0, `idx`=0, `sel`=0, `seg`=8'hFF. The conversion FSM keeps running.

## Timing
- Reset values: `sel`=6'b000000, `seg`=8'hFF, `cnt`=0, `idx`=0, `data_reg`=0, `bcd_disp`=0, FSM=IDLE. Reset during SHIFT aborts the conversion.
- `sel`/`seg` are registered and follow `idx`/`bcd_disp`/`point`/`sign` with 1-cycle latency.
- First cycle after reset release with `seg_en`=1: `sel`=6'b000001 on the next edge.
- Conversion latency: `data` changes and is sampled in IDLE at edge t. `bcd_disp` updates at edge t+20, and `seg` reflects it at edge t+21 if the digit is selected.
- Dwell per digit is exactly CNT_MAX+1 cycles. A full frame is 6·(CNT_MAX+1) cycles. `idx` wraps 5→0 with no gap cycle.
- `seg_en` 1→0 at edge t: blank outputs at t+1. `seg_en` 0→1: scan restarts at digit 0 with a full dwell.
- `bcd_disp` updating mid-dwell changes `seg` within that dwell. This is intended.

## Test plan
All scenarios use CNT_MAX=9.

- **Reset:** hold `sys_rst`=1 for 3 cycles with `data`=0 and `seg_en`=1.
  - During reset: `sel`=0, `seg`=FF.
  - After release: digit0 `seg`=C0 with `sel`=01; digits 1–5 `seg`=FF; each `sel` held 10 cycles.
- **Full number:** `data`=123456, `point`=0.
  - After 21 cycles, digits 0..5 show 82, 92, 99, B0, A4, F9.
  - `sel` sequence is 01, 02, 04, 08, 10, 20, 01.
- **Sign and dp:** `data`=42, `sign`=1, `point`=6'b000010.
  - Digits 0..5 show A4, 19, BF, FF, FF, FF.
  - Then `data`=654321 with `sign`=1: no minus is shown anywhere.
- **Clamp and zero:** `data`=1_000_000 gives all six digits = 90. `data`=0 with `sign`=1 gives digit0=C0, digit1=BF.
- **Enable:** `seg_en`=0 mid-dwell on digit 3.
  - Next cycle: `sel`=0, `seg`=FF.
  - Re-enable: `sel`=01 one cycle later, held 10 cycles.
- **Mid-conversion events:**
  - Change `data` 111→222 five cycles into SHIFT: display shows 111, then 222 about 21 cycles after the first conversion completes.
  - Assert `sys_rst` mid-SHIFT: outputs go to reset values, then `data` is re-converted after release.
